// File: rtl/replay_ctrl.sv
// replay_ctrl: start/stop sequencer for the 4-queue pcap replay reader.
// Optional run watchdog is enabled with `define REPLAY_CTRL_WATCHDOG_EN.
module replay_ctrl #(
  parameter int NUM_QUEUES         = 4,
  parameter int MEM_ADDR_WIDTH     = 19,
  parameter int REPLAY_COUNT_WIDTH = 32,
  parameter int CNT_WIDTH          = MEM_ADDR_WIDTH + 1 + REPLAY_COUNT_WIDTH,
  parameter int WDOG_CYCLES        = 65536
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     cmd_start,
  input  logic                                     cmd_stop,
  input  logic [NUM_QUEUES-1:0]                    cfg_qmask,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]     cfg_addr_low,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]     cfg_addr_high,
  input  logic [NUM_QUEUES*REPLAY_COUNT_WIDTH-1:0] cfg_replay_count,
  input  logic                                     cal_done,
  input  logic [NUM_QUEUES-1:0]                    q_fifo_wr_en,
  output logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]     q_addr_low,
  output logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]     q_addr_high,
  output logic [NUM_QUEUES*REPLAY_COUNT_WIDTH-1:0] q_replay_count,
  output logic [NUM_QUEUES-1:0]                    q_enable,
  output logic [NUM_QUEUES-1:0]                    q_start_replay,
  output logic                                     sw_rst,
  output logic                                     busy,
  output logic [NUM_QUEUES-1:0]                    q_done,
  output logic                                     done_pulse,
  output logic                                     err_cfg,
  output logic                                     err_wdog
);
  localparam int NQ = NUM_QUEUES;
  localparam int AW = MEM_ADDR_WIDTH;
  localparam int RW = REPLAY_COUNT_WIDTH;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RST0, S_RST1, S_WAIT_CAL, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;
  logic r_abort, r_sw_rst, r_busy, r_done_pulse, r_err_cfg;
  logic [NQ-1:0] r_mask, r_done, r_start, w_ok, w_eq, w_hit, w_active;
  logic [NQ*AW-1:0] r_addr_low, r_addr_high;
  logic [NQ*RW-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_exp [NQ];
  logic [CNT_WIDTH-1:0] r_cnt [NQ];
  logic w_take, w_accept, w_stop, w_wdog, w_all_done;
  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      w_ok[i] = !cfg_qmask[i] || (cfg_addr_high[i*AW +: AW] > cfg_addr_low[i*AW +: AW]
                                  && cfg_replay_count[i*RW +: RW] != '0);
      w_eq[i] = r_cnt[i] == r_exp[i];
    end
  end
  // a queue whose counter already matches is finishing; further strobes must not overshoot
  assign w_hit      = r_start & w_eq;
  assign w_active   = r_start & ~w_eq;
  assign w_take     = cmd_start && !cmd_stop && (r_state == S_IDLE || r_state == S_DONE);
  assign w_accept   = w_take && |cfg_qmask && &w_ok;
  assign w_stop     = (cmd_stop && r_state != S_IDLE) || w_wdog;
  assign w_all_done = (r_done & r_mask) == r_mask;
  always_comb begin
    w_next = r_state;
    if (w_stop) w_next = S_RST0;
    else
      case (r_state)
        S_IDLE, S_DONE: w_next = w_take ? (w_accept ? S_LOAD : S_IDLE) : r_state;
        S_LOAD:         w_next = S_RST0;
        S_RST0:         w_next = S_RST1;
        S_RST1:         w_next = r_abort ? S_IDLE : S_WAIT_CAL;
        S_WAIT_CAL:     w_next = cal_done ? S_RUN : S_WAIT_CAL;
        S_RUN:          w_next = w_all_done ? S_DONE : S_RUN;
        default:        w_next = S_IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_abort      <= 1'b0;
      r_sw_rst     <= 1'b0;
      r_busy       <= 1'b0;
      r_done_pulse <= 1'b0;
      r_err_cfg    <= 1'b0;
      r_mask       <= '0;
      r_done       <= '0;
      r_start      <= '0;
      r_addr_low   <= '0;
      r_addr_high  <= '0;
      r_count      <= '0;
      for (int i = 0; i < NQ; i++) begin
        r_exp[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_state      <= w_next;
      r_sw_rst     <= w_next == S_RST0 || w_next == S_RST1;
      r_busy       <= w_next != S_IDLE && w_next != S_DONE;
      r_done_pulse <= r_state == S_RUN && w_next == S_DONE;
      r_start      <= w_next == S_RUN ? r_mask & ~(r_done | w_hit) : '0;
      r_done       <= w_accept ? '0 : r_done | w_hit;
      if (w_stop) r_abort <= 1'b1;
      else if (w_accept) r_abort <= 1'b0;
      if (w_take) r_err_cfg <= !w_accept;
      if (w_accept) begin
        r_mask      <= cfg_qmask;
        r_addr_low  <= cfg_addr_low;
        r_addr_high <= cfg_addr_high;
        r_count     <= cfg_replay_count;
      end
      for (int i = 0; i < NQ; i++) begin
        r_cnt[i] <= r_state == S_LOAD ? '0 : r_cnt[i] + CNT_WIDTH'(w_active[i] && q_fifo_wr_en[i]);
        if (r_state == S_LOAD)
          r_exp[i] <= ({{(CNT_WIDTH-AW){1'b0}}, r_addr_high[i*AW +: AW] - r_addr_low[i*AW +: AW]} << 1)
                      * {{(CNT_WIDTH-RW){1'b0}}, r_count[i*RW +: RW]};
      end
    end
  end
`ifdef REPLAY_CTRL_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] r_wdog_cnt;
  logic r_err_wdog;
  assign w_wdog   = r_state == S_RUN && r_wdog_cnt == WW'(WDOG_CYCLES);
  assign err_wdog = r_err_wdog;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdog_cnt <= '0;
      r_err_wdog <= 1'b0;
    end else begin
      r_wdog_cnt <= (r_state != S_RUN || |(w_active & q_fifo_wr_en)) ? '0 : r_wdog_cnt + 1'b1;
      r_err_wdog <= w_wdog || (r_err_wdog && !w_take);
    end
  end
`else
  assign w_wdog   = 1'b0;
  assign err_wdog = 1'b0;
`endif
  assign q_addr_low     = r_addr_low;
  assign q_addr_high    = r_addr_high;
  assign q_replay_count = r_count;
  assign q_enable       = r_mask;
  assign q_start_replay = r_start;
  assign sw_rst         = r_sw_rst;
  assign busy           = r_busy;
  assign q_done         = r_done;
  assign done_pulse     = r_done_pulse;
  assign err_cfg        = r_err_cfg;
endmodule
